// File: rtl/register_bank.sv
// 32 x WIDTH general register file for the multicycle MIPS datapath.
// It has one write port and two registered read ports with write-through bypass. r0 always reads zero.
module register_bank #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] SP_RESET = WIDTH'(227)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             RegWrite,
  input  logic [4:0]       WriteReg,
  input  logic [WIDTH-1:0] WriteData,
  input  logic [4:0]       ReadReg1,
  input  logic [4:0]       ReadReg2,
  output logic [WIDTH-1:0] ReadData1,
  output logic [WIDTH-1:0] ReadData2
);

  localparam int NUM_REGS = 32;
  localparam int SP_INDEX = 29;

  logic [WIDTH-1:0] regs [NUM_REGS];

  logic write_en;
  logic bypass1;
  logic bypass2;

  // A write to r0 is discarded, so r0 never leaves its reset value of zero.
  // This also keeps the bypass from forwarding a write to r0.
  assign write_en = RegWrite && (WriteReg != 5'd0);
  assign bypass1  = write_en && (WriteReg == ReadReg1);
  assign bypass2  = write_en && (WriteReg == ReadReg2);

  // NOTE: every register in this file, storage included, uses non-blocking assignments.
  // Reads in the same block then see the pre-edge contents, and the bypass muxes supply the new value.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the storage array is reset in full because r29 must come up as the stack pointer.
      // A reset also keeps the first reads after it deterministic.
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= (i == SP_INDEX) ? SP_RESET : '0;
      end
      ReadData1 <= '0;
      ReadData2 <= '0;
    end else begin
      if (write_en) begin
        regs[WriteReg] <= WriteData;
      end
      ReadData1 <= bypass1 ? WriteData : regs[ReadReg1];
      ReadData2 <= bypass2 ? WriteData : regs[ReadReg2];
    end
  end

endmodule

// File: doc/register_bank.md
# register_bank

Register bank of the multicycle MIPS datapath: 32 × 32-bit general registers with one write port and two registered read ports. The write port is the receiving end of the write-address selection path (rt, rd, sp = 29, ra = 31). It commits Write data into the register addressed by that selection. Read ports feed the A/B operand registers and the memory-data path.

## Interface
Parameters:
- SP_RESET, 32'd227, value loaded into r29 (stack pointer) on reset
- WIDTH, 32, register data width

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- RegWrite  input  1  write enable for the write port
- WriteReg  input  5  write address, from the write-address mux output
- WriteData  input  WIDTH  data to be written
- ReadReg1  input  5  read address, port 1 (instruction [25-21])
- ReadReg2  input  5  read address, port 2 (instruction [20-16])
- ReadData1  output  WIDTH  registered read data, port 1
- ReadData2  output  WIDTH  registered read data, port 2

## Operation
- Storage: 32 registers, r0..r31.
- r0 is hardwired to zero.
  - A write to r0 is accepted and discarded.
  - A read of r0 always returns 0, including through the bypass.
- Write:
  - When RegWrite = 1 and WriteReg ≠ 0 on a rising edge, the register at WriteReg takes WriteData.
  - When RegWrite = 0, no register changes.
- Read:
  - On every rising edge, ReadData1 ← value of reg[ReadReg1]; ReadData2 ← value of reg[ReadReg2].
  - Reads never stall; there is no enable.
- Write-through bypass:
  - Applies when, on the same edge, RegWrite = 1, WriteReg ≠ 0 and WriteReg == ReadRegN.
  - In that case ReadDataN takes WriteData, not the old register content.
  - Both ports bypass independently; both may bypass on the same edge.
- Reset (reset = 1 at a rising edge):
  - All registers clear to 0, except r29 = SP_RESET.
  - ReadData1 = ReadData2 = 0.
  - Reset has priority over any write or read in the same cycle: the write is dropped.
- Reset mid-operation: a write presented in the reset cycle is lost. The first read after reset deasserts returns post-reset values (r29 = 227, others 0).
- Data width: full WIDTH bits are stored and returned; no sign or zero handling here.
- Out-of-range addresses cannot occur, since 5 bits addresses all 32 registers.

## Timing
- Write latency: 1 edge. Data presented at edge N is visible in reg at edge N.
- Read latency: 1 edge. ReadReg sampled at edge N appears on ReadDataN after edge N and holds until edge N+1.
- Bypass makes a same-edge write visible on ReadData after that edge. Without the bypass it would appear one edge later.
- No combinational path from any input to ReadData1/ReadData2.
- Reset: synchronous. Outputs read 0 in the cycle after the reset edge.

## Test plan
- Reset then read:
  - Stimulus: reset = 1 for one edge, then ReadReg1 = 29, ReadReg2 = 0.
  - Response: after the next edge ReadData1 = 227, ReadData2 = 0; all outputs are 0 in the cycle right after reset.
- Basic write/read:
  - Stimulus: write r8 = 0xDEADBEEF, then next cycle ReadReg1 = 8, RegWrite = 0.
  - Response: ReadData1 = 0xDEADBEEF one edge later; ReadData2 for ReadReg2 = 9 stays 0.
- r0 protection:
  - Stimulus: RegWrite = 1, WriteReg = 0, WriteData = 0x12345678, ReadReg1 = 0 on the same edge and on the next.
  - Response: ReadData1 = 0 both times.
- Bypass on both ports:
  - Stimulus: RegWrite = 1, WriteReg = 31, WriteData = 0x00400010, ReadReg1 = ReadReg2 = 31 on the same edge.
  - Response: ReadData1 = ReadData2 = 0x00400010 after that edge.
- Reset priority:
  - Stimulus: reset = 1 with RegWrite = 1, WriteReg = 29, WriteData = 0x1000; then read r29.
  - Response: ReadData = 227 (write dropped).
- Sweep:
  - Stimulus: write reg i = i × 0x01010101 for i = 1..31, then read all pairs (i, 31−i).
  - Response: every value matches; r0 reads 0.
